mesh_terminal_port: RTL and testbench

- Synthesizable endpoint that attaches to one terminal port of mesh_gnrtr.
- Injects locally produced packets into the mesh through the pndng_i_in / data_out_i_in / popin handshake.
- Drains packets leaving the mesh through the pndng / data_out / pop handshake.
- Complements the bench's driver/monitor pair; used as the building block for self-checking mesh subsystems.

---
 rtl/mesh_terminal_port_if.sv | 74 +++++++
 rtl/mesh_terminal_port.sv | 248 ++++++++++++++++++++++++
 tb/tb_mesh_terminal_port.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_terminal_port_if.sv
// -----------------------------------------------------------------------------
// mesh_terminal_port_if
//
// Purpose: bundles the two handshakes of a mesh terminal endpoint. The mesh
// side (pndng/data_out/pop for traffic leaving the mesh, pndng_i_in/
// data_out_i_in/popin for traffic entering it) and the local side
// (tx_* for packets to send, rx_* for packets received).
//
// Modports:
//   master - the terminal endpoint (mesh_terminal_port).
//            inputs : pndng, data_out, popin, tx_data, tx_valid, rx_ready
//            outputs: pop, pndng_i_in, data_out_i_in, tx_ready, rx_data,
//                     rx_valid
//   slave  - the environment around the endpoint (mesh port plus local
//            producer/consumer); directions mirrored.
//
// Parameters:
//   pckg_sz - packet width in bits.
// -----------------------------------------------------------------------------
interface mesh_terminal_port_if #(
    parameter int pckg_sz = 40
) ();

    // Mesh -> terminal
    logic               pndng;
    logic [pckg_sz-1:0] data_out;
    logic               pop;

    // Terminal -> mesh
    logic               pndng_i_in;
    logic [pckg_sz-1:0] data_out_i_in;
    logic               popin;

    // Local producer
    logic [pckg_sz-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    // Local consumer
    logic [pckg_sz-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;

    modport master (
        input  pndng,
        input  data_out,
        input  popin,
        input  tx_data,
        input  tx_valid,
        input  rx_ready,
        output pop,
        output pndng_i_in,
        output data_out_i_in,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

    modport slave (
        output pndng,
        output data_out,
        output popin,
        output tx_data,
        output tx_valid,
        output rx_ready,
        input  pop,
        input  pndng_i_in,
        input  data_out_i_in,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/mesh_terminal_port.sv
// -----------------------------------------------------------------------------
// mesh_terminal_port
//
// Purpose: endpoint for one terminal port of the mesh. Local packets are
// queued in a first-word-fall-through TX FIFO and offered to the mesh;
// packets leaving the mesh are pulled by a three-state RX FSM
// (IDLE -> POP -> GUARD) into a first-word-fall-through RX FIFO.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   bus       mesh_terminal_port_if.master
//                  mesh side : pndng, data_out, pop, pndng_i_in,
//                              data_out_i_in, popin
//                  local side: tx_data, tx_valid, tx_ready,
//                              rx_data, rx_valid, rx_ready
//   tx_cnt    out  words popped by the mesh (saturating)
//   rx_cnt    out  words written to the RX buffer (saturating)
//   drop_cnt  out  received words discarded by the ID filter (saturating)
//
// Packet fields: [pckg_sz-1 -: 8] next-jump, [pckg_sz-9 -: 4] target row,
// [pckg_sz-13 -: 4] target column, [pckg_sz-17] mode, low bits payload.
//
// Build option: define TERM_ID_CHECK_EN to accept only words addressed to
// (id_row, id_column) or to the broadcast address (F, F). Without it every
// captured word is accepted and drop_cnt is tied to zero.
// -----------------------------------------------------------------------------
module mesh_terminal_port #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int id_row     = 0,
    parameter int id_column  = 0,
    parameter int cnt_w      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    mesh_terminal_port_if.master    bus,
    output logic [cnt_w-1:0]        tx_cnt,
    output logic [cnt_w-1:0]        rx_cnt,
    output logic [cnt_w-1:0]        drop_cnt
);

    localparam int              ptr_w    = $clog2(fifo_depth);
    localparam logic [ptr_w:0]  occ_full = (ptr_w + 1)'(fifo_depth);
    localparam logic [3:0]      my_row   = 4'(id_row);
    localparam logic [3:0]      my_col   = 4'(id_column);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_POP,
        RX_GUARD
    } rx_state_t;

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [pckg_sz-1:0] tx_mem [fifo_depth];
    logic [ptr_w-1:0]   tx_wr_ptr;
    logic [ptr_w-1:0]   tx_rd_ptr;
    logic [ptr_w:0]     tx_occ;
    logic               tx_empty;
    logic               tx_full;
    logic               tx_push;
    logic               tx_pop;

    assign tx_empty = (tx_occ == '0);
    assign tx_full  = (tx_occ == occ_full);
    assign tx_push  = bus.tx_valid && !tx_full;
    assign tx_pop   = bus.popin && !tx_empty;

    assign bus.tx_ready      = !tx_full;
    assign bus.pndng_i_in    = !tx_empty;
    assign bus.data_out_i_in = tx_empty ? '0 : tx_mem[tx_rd_ptr];

    // Storage carries no reset; the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (!reset && tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.tx_data;
        end
    end

    // Pointer/occupancy bookkeeping and the mesh-pop statistic.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_occ    <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
                if (tx_cnt != '1) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_occ <= tx_occ + 1'b1;
                2'b01:   tx_occ <= tx_occ - 1'b1;
                default: tx_occ <= tx_occ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RX FIFO status
    // -------------------------------------------------------------------------
    logic [pckg_sz-1:0] rx_mem [fifo_depth];
    logic [ptr_w-1:0]   rx_wr_ptr;
    logic [ptr_w-1:0]   rx_rd_ptr;
    logic [ptr_w:0]     rx_occ;
    logic               rx_empty;
    logic               rx_full;
    logic               rx_push;
    logic               rx_read;
    logic               rx_slot_free;

    assign rx_empty     = (rx_occ == '0);
    assign rx_full      = (rx_occ == occ_full);
    assign rx_read      = bus.rx_ready && !rx_empty;
    // A read in the same cycle frees a slot before the capture lands, which
    // happens two edges later at the earliest.
    assign rx_slot_free = !rx_full || rx_read;

    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];

    // -------------------------------------------------------------------------
    // RX FSM
    // -------------------------------------------------------------------------
    rx_state_t rx_state;
    rx_state_t rx_state_next;
    logic      pop_now;
    logic      rx_capture;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    // GUARD exists so that pndng, which the mesh may still be updating after
    // a pop, is never looked at in the cycle right after the pop.
    always_comb begin
        rx_state_next = rx_state;
        pop_now       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (bus.pndng && rx_slot_free) begin
                    rx_state_next = RX_POP;
                end
            end
            RX_POP: begin
                pop_now       = 1'b1;
                rx_state_next = RX_GUARD;
            end
            RX_GUARD: begin
                rx_state_next = RX_IDLE;
            end
            default: begin
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    assign bus.pop    = pop_now;
    assign rx_capture = (rx_state == RX_POP);

    // -------------------------------------------------------------------------
    // Address filter
    // -------------------------------------------------------------------------
    logic [3:0] tgt_row;
    logic [3:0] tgt_col;
    logic       id_match;
    logic       rx_accept;

    assign tgt_row  = bus.data_out[pckg_sz-9 -: 4];
    assign tgt_col  = bus.data_out[pckg_sz-13 -: 4];
    assign id_match = ((tgt_row == my_row) && (tgt_col == my_col)) ||
                      ((tgt_row == 4'hF) && (tgt_col == 4'hF));

`ifdef TERM_ID_CHECK_EN
    logic rx_drop;

    assign rx_accept = id_match;
    assign rx_drop   = rx_capture && !id_match;

    // Rejected words are still popped so the mesh never stalls on them.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (rx_drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    logic unused_id_match;

    // The address comparison has no consumer when filtering is compiled out.
    assign unused_id_match = id_match;
    assign rx_accept       = 1'b1;
    assign drop_cnt        = '0;
`endif

    assign rx_push = rx_capture && rx_accept;

    // -------------------------------------------------------------------------
    // RX FIFO storage and bookkeeping
    // -------------------------------------------------------------------------

    // data_out is taken on the edge that ends the POP cycle.
    always_ff @(posedge clk) begin
        if (!reset && rx_push) begin
            rx_mem[rx_wr_ptr] <= bus.data_out;
        end
    end

    // Pointer/occupancy bookkeeping and the accepted-word statistic.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_occ    <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
                if (rx_cnt != '1) begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end
            if (rx_read) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push, rx_read})
                2'b10:   rx_occ <= rx_occ + 1'b1;
                2'b01:   rx_occ <= rx_occ - 1'b1;
                default: rx_occ <= rx_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_terminal_port.sv
// -----------------------------------------------------------------------------
// tb_mesh_terminal_port
//
// Bench for mesh_terminal_port. A stimulus process plays directed scenarios
// followed by a randomized phase; a mesh-side driver feeds the pndng/data_out
// handshake from a queue; a negedge monitor keeps a queue-based reference of
// both FIFOs, the counters and the pop-timing rule and compares every cycle.
// -----------------------------------------------------------------------------
module tb_mesh_terminal_port;

    localparam int PKW    = 40;
    localparam int DEPTH  = 4;
    localparam int ID_ROW = 1;
    localparam int ID_COL = 2;
    localparam int CW     = 16;

`ifdef TERM_ID_CHECK_EN
    localparam bit ID_FILTER = 1'b1;
`else
    localparam bit ID_FILTER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    mesh_terminal_port_if #(.pckg_sz(PKW)) bus ();

    mesh_terminal_port #(
        .pckg_sz    (PKW),
        .fifo_depth (DEPTH),
        .id_row     (ID_ROW),
        .id_column  (ID_COL),
        .cnt_w      (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_cnt   (tx_cnt),
        .rx_cnt   (rx_cnt),
        .drop_cnt (drop_cnt)
    );

    // Words waiting inside the mesh for this terminal
    logic [PKW-1:0] mesh_q[$];
    // Reference contents of the TX and RX buffers
    logic [PKW-1:0] tx_exp_q[$];
    logic [PKW-1:0] rx_exp_q[$];

    int unsigned tx_cnt_m;
    int unsigned rx_cnt_m;
    int unsigned drop_cnt_m;
    bit          exp_pop;
    bit          prev_pop;
    int          checks;
    int          errors;

    function automatic logic [PKW-1:0] make_pkt(input logic [3:0] row, input logic [3:0] col,
                                                input logic mode, input logic [22:0] payload);
        return {8'h00, row, col, mode, payload};
    endfunction

    function automatic bit expect_accept(input logic [PKW-1:0] w);
        logic [3:0] r;
        logic [3:0] c;
        bit         addressed;
        r = w[PKW-9 -: 4];
        c = w[PKW-13 -: 4];
        addressed = ((r == 4'(ID_ROW)) && (c == 4'(ID_COL))) || ((r == 4'hF) && (c == 4'hF));
        return !ID_FILTER || addressed;
    endfunction

    function automatic logic [PKW-1:0] rand_pkt();
        logic [3:0] r;
        logic [3:0] c;
        case ($urandom_range(0, 3))
            0:       begin r = 4'(ID_ROW); c = 4'(ID_COL); end
            1:       begin r = 4'hF;       c = 4'hF;       end
            2:       begin r = 4'h3;       c = 4'h0;       end
            default: begin r = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15)); end
        endcase
        return make_pkt(r, c, 1'($urandom_range(0, 1)), 23'($urandom));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit tv, input logic [PKW-1:0] td,
                                 input bit pi, input bit rr);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.tx_valid = tv;
        bus.tx_data  = td;
        bus.popin    = pi;
        bus.rx_ready = rr;
    endtask

    // Mesh-side driver: presents the head of mesh_q and retires it after a pop.
    initial begin
        bit took;
        bus.pndng    = 1'b0;
        bus.data_out = '0;
        forever begin
            @(negedge clk);
            took = bus.pop;
            @(posedge clk);
            #2;
            if (took && (mesh_q.size() > 0)) begin
                void'(mesh_q.pop_front());
            end
            bus.pndng    = (mesh_q.size() > 0);
            bus.data_out = (mesh_q.size() > 0) ? mesh_q[0] : '0;
        end
    end

    // Monitor / scoreboard: compares, then advances the reference to the next edge.
    always @(negedge clk) begin
        bit tx_full_m;
        bit slot_free;
        bit next_pop;

        checkOutput("pop",           64'(bus.pop),           64'(exp_pop));
        checkOutput("tx_ready",      64'(bus.tx_ready),      64'(tx_exp_q.size() < DEPTH));
        checkOutput("pndng_i_in",    64'(bus.pndng_i_in),    64'(tx_exp_q.size() > 0));
        checkOutput("data_out_i_in", 64'(bus.data_out_i_in), 64'((tx_exp_q.size() > 0) ? tx_exp_q[0] : '0));
        checkOutput("rx_valid",      64'(bus.rx_valid),      64'(rx_exp_q.size() > 0));
        checkOutput("rx_data",       64'(bus.rx_data),       64'((rx_exp_q.size() > 0) ? rx_exp_q[0] : '0));
        checkOutput("tx_cnt",        64'(tx_cnt),            64'(tx_cnt_m));
        checkOutput("rx_cnt",        64'(rx_cnt),            64'(rx_cnt_m));
        checkOutput("drop_cnt",      64'(drop_cnt),          64'(drop_cnt_m));

        if (reset) begin
            tx_exp_q.delete();
            rx_exp_q.delete();
            tx_cnt_m   = 0;
            rx_cnt_m   = 0;
            drop_cnt_m = 0;
            exp_pop    = 1'b0;
            prev_pop   = 1'b0;
        end else begin
            // A pop may start only after two quiet cycles, with a word pending
            // and room in the RX buffer (a read this cycle makes room).
            slot_free = (rx_exp_q.size() < DEPTH) || (bus.rx_ready && (rx_exp_q.size() > 0));
            next_pop  = !exp_pop && !prev_pop && bus.pndng && slot_free;

            tx_full_m = (tx_exp_q.size() == DEPTH);
            if (bus.popin && (tx_exp_q.size() > 0)) begin
                void'(tx_exp_q.pop_front());
                if (tx_cnt_m < 32'hFFFF) tx_cnt_m++;
            end
            if (bus.tx_valid && !tx_full_m) begin
                tx_exp_q.push_back(bus.tx_data);
            end

            if (bus.rx_ready && (rx_exp_q.size() > 0)) begin
                void'(rx_exp_q.pop_front());
            end
            if (exp_pop) begin
                if (expect_accept(bus.data_out)) begin
                    rx_exp_q.push_back(bus.data_out);
                    if (rx_cnt_m < 32'hFFFF) rx_cnt_m++;
                end else begin
                    if (drop_cnt_m < 32'hFFFF) drop_cnt_m++;
                end
            end

            prev_pop = exp_pop;
            exp_pop  = next_pop;
        end
    end

    // Stimulus
    initial begin
        int pops;
        checks       = 0;
        errors       = 0;
        tx_cnt_m     = 0;
        rx_cnt_m     = 0;
        drop_cnt_m   = 0;
        exp_pop      = 1'b0;
        prev_pop     = 1'b0;
        reset        = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = make_pkt(4'h1, 4'h1, 1'b0, 23'h7FFFFF);
        bus.popin    = 1'b0;
        bus.rx_ready = 1'b0;

        $display("[TB] reset held with tx_valid asserted");
        repeat (4) applyStimulus(1'b1, 1'b1, make_pkt(4'h1, 4'h1, 1'b0, 23'h7FFFFF), 1'b0, 1'b0);

        $display("[TB] TX fill to full, fifth word refused, then drain");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, make_pkt(4'h1, 4'h1, 1'b0, 23'h2AAA0 + 23'(i)), 1'b0, 1'b0);
        end
        repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] RX continuous pending, three words");
        for (int i = 0; i < 3; i++) mesh_q.push_back(make_pkt(4'(ID_ROW), 4'(ID_COL), 1'b1, 23'h100 + 23'(i)));
        repeat (15) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] RX back-pressure, six words");
        for (int i = 0; i < 6; i++) mesh_q.push_back(make_pkt(4'hF, 4'hF, 1'b0, 23'h200 + 23'(i)));
        repeat (30) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (25) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] RX address filter targets");
        mesh_q.push_back(make_pkt(4'h1, 4'h2, 1'b0, 23'h301));
        mesh_q.push_back(make_pkt(4'h3, 4'h0, 1'b0, 23'h302));
        mesh_q.push_back(make_pkt(4'hF, 4'hF, 1'b0, 23'h303));
        repeat (15) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] reset right after a pop with two words buffered");
        for (int i = 0; i < 4; i++) mesh_q.push_back(make_pkt(4'hF, 4'hF, 1'b1, 23'h400 + 23'(i)));
        pops = 0;
        for (int i = 0; i < 40 && pops < 2; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.pop) pops++;
        end
        checks++;
        if (pops < 2) begin
            errors++;
            $display("[TB] FAIL reset_setup_pops actual=%0d expected=2", pops);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        repeat (15) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            if ((mesh_q.size() < 3) && ($urandom_range(0, 2) == 0)) mesh_q.push_back(rand_pkt());
            applyStimulus(($urandom_range(0, 299) == 0),
                          1'($urandom_range(0, 1)),
                          rand_pkt(),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
        end

        repeat (40) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
